acc_block_sat: RTL and testbench
================================

Name: acc_block_sat

Overview:
- Parametrised successor to the fixed 8-in/12-out accumulator.
- Accumulates signed samples qualified by i_valid in one of two modes:
  - running sum, updated on every sample;
  - block sum, dumped and restarted every BLOCK_LEN samples.
- Adds synchronous clear, sticky overflow detection and a sample counter.
- Sits between a sample source and downstream averaging/decimation logic.

Parameters:
- DATA_W, 8, signed input sample width.
- ACC_W, 12, signed accumulator/output width; legal only if ACC_W >= DATA_W+1.
- BLOCK_LEN, 16, samples per block in block mode; legal only if >= 1.
- CNT_W, $clog2(BLOCK_LEN+1), counter width (derived, not overridden).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_valid  input  1  i_x carries a sample this cycle.
- i_x  input  DATA_W  signed sample.
- i_mode  input  1  0 = running, 1 = block.
- i_clear  input  1  synchronous clear of accumulation state.
- o_acc  output  ACC_W  signed result.
- o_valid  output  1  o_acc updated this cycle (one-cycle pulse per update).
- o_count  output  CNT_W  samples accumulated in the current block (0 in running mode).
- o_ovf  output  1  sticky signed-overflow flag.

Behaviour:
- **Reset.** One clock; reset is synchronous and active-high (i_rst, sampled on rising i_clk). While i_rst=1:
  - acc, o_acc, o_count = 0; o_valid = 0; o_ovf = 0;
  - the registered mode copy takes i_mode.
- **Priority each cycle:** i_rst > i_clear > mode change > i_valid.
- **Sign extension.** i_x is sign-extended to ACC_W+1 bits; sum = acc + sx(i_x) is computed at ACC_W+1 bits.
- **Overflow.** Flagged when sum lies outside [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Default: the stored result wraps to the low ACC_W bits (two's complement).
  - o_ovf sets on any overflow and stays set until i_rst or i_clear.
- **Running mode (mode=0).** On i_valid:
  - acc <= result; o_acc <= result; o_valid = 1 on the next cycle (latency 1).
  - Cycles without i_valid: o_valid = 0; acc and o_acc hold.
- **Block mode (mode=1).** On i_valid with o_count < BLOCK_LEN-1: acc <= result; o_count++; o_valid = 0; o_acc holds the previous block result.
- **Block end.** On i_valid with o_count == BLOCK_LEN-1:
  - o_acc <= result; o_valid = 1 next cycle;
  - acc <= 0; o_count <= 0 (the next sample starts a fresh block with no lost cycle).
  - BLOCK_LEN=1: every sample produces a pulse with o_acc = sx(i_x).
- **Gaps.** i_valid gaps inside a block are permitted; the block ends only on the BLOCK_LEN-th valid sample.
- **i_clear.** acc, o_acc, o_count <= 0; o_ovf <= 0; o_valid <= 0.
  - An i_valid arriving in the same cycle is discarded.
- **Mode change.** When i_mode differs from the registered mode, the registered mode updates and an implicit clear is applied (same effect as i_clear, including discarding the same-cycle sample). A partial block is never emitted.
- **Reset mid-block.** The partial sum is lost; no o_valid is produced.

Optional Feature:
- Macro ACC_SAT_EN.
- Defined: on overflow, the stored result clamps to 2^(ACC_W-1)-1 (positive overflow) or -2^(ACC_W-1) (negative overflow) instead of wrapping. o_ovf still sets. Block-mode dump and restart are unchanged.
- Undefined: wrap-around as specified above. No saturation logic is synthesised.

Test Plan:
All scenarios use DATA_W=8, ACC_W=12, BLOCK_LEN=16.
1. i_rst=1 for 2 cycles with i_valid=1, i_x=5 -> o_acc=0, o_valid=0, o_count=0, o_ovf=0 throughout; first sample after release gives o_acc=5 one cycle later.
2. Running mode, i_x=1, i_valid=1 for 40 cycles -> o_acc steps 1..40, o_valid high for 40 consecutive cycles each lagging its sample by 1, o_ovf=0.
3. Block mode, i_x=1 for 40 samples -> o_valid pulses exactly twice (after samples 16 and 32) with o_acc=16 both times; final o_count=8.
4. Running mode, i_x=127 for 17 samples -> after 16 o_acc=2032; 17th gives -1937 (wrap), o_ovf=1 and held; ACC_SAT_EN build gives 2047. Repeat with i_x=-128: 16th gives -2048 with no overflow; 17th gives 1920 (wrap) or -2048 (sat), o_ovf=1.
5. Block mode, 10 samples of 3, then i_clear=1 with i_valid=1 and i_x=9 -> no pulse, o_count=0, sample discarded; then 16 samples of 2 with i_valid toggling every other cycle -> single pulse with o_acc=32.
6. Running mode, 5 samples of 4 (o_acc=20), toggle i_mode to 1 with i_valid=1 -> implicit clear, o_acc=0, sample dropped; the next 16 samples of 1 give one pulse with o_acc=16.

Source files
------------

// File: rtl/acc_block_sat.sv
// acc_block_sat: signed sample accumulator with running and block modes.
// It has synchronous clear, a sticky overflow flag and a per-block sample counter.
// Optional build macro ACC_SAT_EN: when defined, overflowing sums clamp to the
// accumulator range. When undefined, they wrap (two's complement).
module acc_block_sat #(
  parameter  int DATA_W    = 8,
  parameter  int ACC_W     = 12,
  parameter  int BLOCK_LEN = 16,
  localparam int CNT_W     = $clog2(BLOCK_LEN + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  input  logic signed [DATA_W-1:0] i_x,
  input  logic                     i_mode,
  input  logic                     i_clear,
  output logic signed [ACC_W-1:0]  o_acc,
  output logic                     o_valid,
  output logic [CNT_W-1:0]         o_count,
  output logic                     o_ovf
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_LEN - 1);

  logic                    mode_q,  mode_d;
  logic signed [ACC_W-1:0] acc_q,   acc_d;
  logic signed [ACC_W-1:0] o_acc_q, o_acc_d;
  logic                    valid_q, valid_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    ovf_q,   ovf_d;

  logic signed [ACC_W:0]   sum_w;
  logic                    sum_ovf;
  logic signed [ACC_W-1:0] result;

  // One-bit-wider sum of the accumulator and the sign-extended sample, plus the stored result
  always_comb begin
    sum_w   = {acc_q[ACC_W-1], acc_q} + {{(ACC_W + 1 - DATA_W){i_x[DATA_W-1]}}, i_x};
    sum_ovf = sum_w[ACC_W] != sum_w[ACC_W-1];
`ifdef ACC_SAT_EN
    if (sum_ovf) begin
      result = sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      result = sum_w[ACC_W-1:0];
    end
`else
    result = sum_w[ACC_W-1:0];
`endif
  end

  // Next-state rules: clear (explicit or caused by a mode change) beats a sample
  always_comb begin
    mode_d  = i_mode;
    acc_d   = acc_q;
    o_acc_d = o_acc_q;
    valid_d = 1'b0;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (i_clear || (i_mode != mode_q)) begin
      acc_d   = '0;
      o_acc_d = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (i_valid) begin
      if (sum_ovf) begin
        ovf_d = 1'b1;
      end
      if (!mode_q) begin
        acc_d   = result;
        o_acc_d = result;
        valid_d = 1'b1;
      end else if (count_q == LAST_IDX) begin
        o_acc_d = result;
        acc_d   = '0;
        count_d = '0;
        valid_d = 1'b1;
      end else begin
        acc_d   = result;
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  // State registers; reset zeroes everything and captures the current mode
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mode_q  <= i_mode;
      acc_q   <= '0;
      o_acc_q <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      o_acc_q <= o_acc_d;
      valid_q <= valid_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_acc   = o_acc_q;
  assign o_valid = valid_q;
  assign o_count = count_q;
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_acc_block_sat.sv
// Testbench for acc_block_sat (DATA_W=8, ACC_W=12, BLOCK_LEN=16).
// It runs the directed scenarios first and then a randomized stream.
// A behavioural integer model checks the DUT on every cycle.
module tb_acc_block_sat;

   localparam int DATA_W    = 8;
   localparam int ACC_W     = 12;
   localparam int BLOCK_LEN = 16;
   localparam int CNT_W     = $clog2(BLOCK_LEN + 1);
   localparam int ACC_MAX   = 2047;
   localparam int ACC_MIN   = -2048;

   logic                     clk;
   logic                     rst;
   logic                     inValid;
   logic signed [DATA_W-1:0] inX;
   logic                     inMode;
   logic                     inClear;
   logic signed [ACC_W-1:0]  outAcc;
   logic                     outValid;
   logic [CNT_W-1:0]         outCount;
   logic                     outOvf;

   int total = 0;
   int bad   = 0;
   int pulses;

   int modelAcc;
   int modelOut;
   bit modelValid;
   int modelCount;
   bit modelOvf;
   bit modelMode;

   acc_block_sat #(
      .DATA_W(DATA_W),
      .ACC_W(ACC_W),
      .BLOCK_LEN(BLOCK_LEN)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_valid(inValid),
      .i_x(inX),
      .i_mode(inMode),
      .i_clear(inClear),
      .o_acc(outAcc),
      .o_valid(outValid),
      .o_count(outCount),
      .o_ovf(outOvf)
   );

   // Free-running clock, 10 time units per period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count one comparison and report it when observed and expected differ
   task automatic checkOutput(input string tag, input int observed, input int expected);
      total++;
      if (observed != expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Apply one cycle of the accumulation rules at the integer level
   task automatic modelStep(input bit r, input bit v, input int x, input bit m, input bit c);
      int sum;
      int res;
      if (r) begin
         modelAcc = 0; modelOut = 0; modelValid = 0; modelCount = 0; modelOvf = 0;
         modelMode = m;
      end else if (c || (m != modelMode)) begin
         modelAcc = 0; modelOut = 0; modelValid = 0; modelCount = 0; modelOvf = 0;
         modelMode = m;
      end else begin
         modelValid = 0;
         if (v) begin
            sum = modelAcc + x;
            res = sum;
            if (sum > ACC_MAX || sum < ACC_MIN) begin
               modelOvf = 1;
`ifdef ACC_SAT_EN
               res = (sum > ACC_MAX) ? ACC_MAX : ACC_MIN;
`else
               res = (sum > ACC_MAX) ? sum - 4096 : sum + 4096;
`endif
            end
            if (!modelMode) begin
               modelAcc = res; modelOut = res; modelValid = 1;
            end else if (modelCount == BLOCK_LEN - 1) begin
               modelOut = res; modelAcc = 0; modelCount = 0; modelValid = 1;
            end else begin
               modelAcc = res; modelCount++;
            end
         end
      end
   endtask

   // Drive one cycle, advance the model, then compare all outputs shortly after the edge
   task automatic applyStimulus(input bit r, input bit v, input int x, input bit m, input bit c);
      rst = r; inValid = v; inX = DATA_W'(x); inMode = m; inClear = c;
      @(posedge clk);
      modelStep(r, v, x, m, c);
      #1;
      checkOutput("acc",   int'(outAcc), modelOut);
      checkOutput("valid", int'(outValid), int'(modelValid));
      checkOutput("count", int'(outCount), modelCount);
      checkOutput("ovf",   int'(outOvf), int'(modelOvf));
      if (outValid) pulses++;
   endtask

   initial begin
      rst = 1'b1; inValid = 1'b0; inX = '0; inMode = 1'b0; inClear = 1'b0;
      modelAcc = 0; modelOut = 0; modelValid = 0; modelCount = 0; modelOvf = 0; modelMode = 0;
      pulses = 0;
      @(negedge clk);

      // Reset held with a sample present, then the first sample after release
      applyStimulus(1, 1, 5, 0, 0);
      applyStimulus(1, 1, 5, 0, 0);
      checkOutput("rst_acc", int'(outAcc), 0);
      applyStimulus(0, 1, 5, 0, 0);
      checkOutput("first_acc", int'(outAcc), 5);
      checkOutput("first_valid", int'(outValid), 1);

      // Running mode: step by one for 40 samples
      applyStimulus(0, 0, 0, 0, 1);
      for (int i = 0; i < 40; i++) begin
         applyStimulus(0, 1, 1, 0, 0);
         checkOutput("run_step", int'(outAcc), i + 1);
      end
      checkOutput("run_ovf", int'(outOvf), 0);

      // Block mode: 40 ones give two block dumps of 16
      applyStimulus(0, 0, 0, 1, 0);
      pulses = 0;
      for (int i = 0; i < 40; i++) applyStimulus(0, 1, 1, 1, 0);
      checkOutput("blk_pulses", pulses, 2);
      checkOutput("blk_acc", int'(outAcc), 16);
      checkOutput("blk_count", int'(outCount), 8);

      // Positive overflow in running mode
      applyStimulus(0, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) applyStimulus(0, 1, 127, 0, 0);
      checkOutput("pos16", int'(outAcc), 2032);
      applyStimulus(0, 1, 127, 0, 0);
`ifdef ACC_SAT_EN
      checkOutput("pos17", int'(outAcc), 2047);
`else
      checkOutput("pos17", int'(outAcc), -1937);
`endif
      checkOutput("pos_ovf", int'(outOvf), 1);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("ovf_hold", int'(outOvf), 1);

      // Negative boundary and negative overflow
      applyStimulus(0, 0, 0, 0, 1);
      for (int i = 0; i < 16; i++) applyStimulus(0, 1, -128, 0, 0);
      checkOutput("neg16", int'(outAcc), -2048);
      checkOutput("neg16_ovf", int'(outOvf), 0);
      applyStimulus(0, 1, -128, 0, 0);
`ifdef ACC_SAT_EN
      checkOutput("neg17", int'(outAcc), -2048);
`else
      checkOutput("neg17", int'(outAcc), 1920);
`endif
      checkOutput("neg_ovf", int'(outOvf), 1);

      // Clear inside a block discards the same-cycle sample; gapped block follows
      applyStimulus(0, 0, 0, 1, 0);
      for (int i = 0; i < 10; i++) applyStimulus(0, 1, 3, 1, 0);
      checkOutput("clr_pre_count", int'(outCount), 10);
      applyStimulus(0, 1, 9, 1, 1);
      checkOutput("clr_count", int'(outCount), 0);
      checkOutput("clr_valid", int'(outValid), 0);
      pulses = 0;
      for (int i = 0; i < 32; i++) applyStimulus(0, (i % 2) == 0, 2, 1, 0);
      checkOutput("gap_pulses", pulses, 1);
      checkOutput("gap_acc", int'(outAcc), 32);

      // Mode change acts as a clear and drops its sample
      applyStimulus(0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) applyStimulus(0, 1, 4, 0, 0);
      checkOutput("mc_pre", int'(outAcc), 20);
      applyStimulus(0, 1, 4, 1, 0);
      checkOutput("mc_acc", int'(outAcc), 0);
      pulses = 0;
      for (int i = 0; i < 16; i++) applyStimulus(0, 1, 1, 1, 0);
      checkOutput("mc_pulses", pulses, 1);
      checkOutput("mc_blk", int'(outAcc), 16);

      // Randomized traffic including rare reset, clear and mode flips
      for (int i = 0; i < 800; i++) begin
         bit r, v, c, m;
         int x;
         r = ($urandom_range(0, 99) < 2);
         c = ($urandom_range(0, 99) < 3);
         v = ($urandom_range(0, 99) < 75);
         m = ($urandom_range(0, 99) < 3) ? ~inMode : inMode;
         x = $urandom_range(0, 255) - 128;
         applyStimulus(r, v, x, m, c);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
